// File: rtl/riscv_vec_mem_lane_unit.sv
// ---------------------------------------------------------------------------
// riscv_vec_mem_lane_unit
//
// Purpose:
//   Vector memory front-end. One core vector load/store request is split into
//   NLANES per-lane element requests at addr + i*stride. Only lanes below the
//   vector length are used. Each lane handshakes with its own memory port.
//   The per-lane responses are gathered into one packed result, and that
//   result goes back to the core over a val/rdy handshake.
//
// Optional feature:
//   RISCV_VECMEM_MASK_EN - adds input i_req_mask, which is latched when a
//   request is accepted. A masked lane never issues and returns 0.
//
// Ports:
//   i_clk, i_rst_n                clock (rising edge), async active-low reset
//   i_req_val / o_req_rdy         core request handshake
//   i_req_rw                      0 = load, 1 = store
//   i_req_len                     element length code, sent to every lane
//   i_req_addr, i_req_stride      base address and signed element stride
//   i_req_vl                      active element count (clamped to NLANES)
//   i_req_data                    store data, lane i at [i*DW +: DW]
//   o_resp_val / i_resp_rdy       gathered result handshake
//   o_resp_data                   load data, lane i at [i*DW +: DW]
//   o_memreq_val / i_memreq_rdy   per-lane memory request handshake
//   o_memreq_rw, o_memreq_len     registered request kind and length
//   o_memreq_addr, o_memreq_data  per-lane address and store data
//   i_memresp_val, i_memresp_data per-lane responses (always accepted)
// ---------------------------------------------------------------------------
module riscv_vec_mem_lane_unit #(
  parameter int NLANES = 8,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int VLW    = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req_val,
  output logic                 o_req_rdy,
  input  logic                 i_req_rw,
  input  logic [1:0]           i_req_len,
  input  logic [AW-1:0]        i_req_addr,
  input  logic [AW-1:0]        i_req_stride,
  input  logic [VLW-1:0]       i_req_vl,
  input  logic [NLANES*DW-1:0] i_req_data,
`ifdef RISCV_VECMEM_MASK_EN
  input  logic [NLANES-1:0]    i_req_mask,
`endif
  output logic                 o_resp_val,
  input  logic                 i_resp_rdy,
  output logic [NLANES*DW-1:0] o_resp_data,
  output logic [NLANES-1:0]    o_memreq_val,
  input  logic [NLANES-1:0]    i_memreq_rdy,
  output logic                 o_memreq_rw,
  output logic [1:0]           o_memreq_len,
  output logic [NLANES*AW-1:0] o_memreq_addr,
  output logic [NLANES*DW-1:0] o_memreq_data,
  input  logic [NLANES-1:0]    i_memresp_val,
  input  logic [NLANES*DW-1:0] i_memresp_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]           r_state;
  logic                 r_rw;
  logic [1:0]           r_len;
  logic [AW-1:0]        r_addr;
  logic [AW-1:0]        r_stride;
  logic [NLANES*DW-1:0] r_data;
  logic [NLANES-1:0]    r_active;
  logic [NLANES-1:0]    r_issued;
  logic [NLANES-1:0]    r_done;
  logic [NLANES*DW-1:0] r_resp_data;

  logic                 w_req_fire;
  logic                 w_busy;
  logic [NLANES-1:0]    w_new_active;
  logic [NLANES-1:0]    w_memreq_val;
  logic [NLANES-1:0]    w_memreq_fire;
  logic [NLANES-1:0]    w_capture;
  logic                 w_all_done;

  assign w_req_fire = (r_state == ST_IDLE) && i_req_val;
  assign w_busy     = (r_state == ST_BUSY);

  // Lane i is active when i < vl. The lane index never reaches NLANES, so a
  // vl larger than NLANES is clamped without any extra logic.
  always_comb begin
    w_new_active = '0;
    for (int i = 0; i < NLANES; i++) begin
      w_new_active[i] = (VLW'(i) < i_req_vl);
    end
`ifdef RISCV_VECMEM_MASK_EN
    w_new_active = w_new_active & i_req_mask;
`endif
  end

  assign w_memreq_val  = w_busy ? (r_active & ~r_issued) : '0;
  assign w_memreq_fire = w_memreq_val & i_memreq_rdy;

  // Only the first response on an issued lane counts. Stray responses are
  // dropped here, and that includes late ones that arrive after a reset.
  assign w_capture  = w_busy ? (i_memresp_val & r_issued & ~r_done) : '0;
  assign w_all_done = ((r_done | w_capture) == r_active);

  // Control FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_fire) begin
            r_state <= (w_new_active == '0) ? ST_RESP : ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_all_done) begin
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (i_resp_rdy) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Request latch, plus per-lane issue and completion bookkeeping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rw     <= 1'b0;
      r_len    <= '0;
      r_addr   <= '0;
      r_stride <= '0;
      r_data   <= '0;
      r_active <= '0;
      r_issued <= '0;
      r_done   <= '0;
    end else if (w_req_fire) begin
      r_rw     <= i_req_rw;
      r_len    <= i_req_len;
      r_addr   <= i_req_addr;
      r_stride <= i_req_stride;
      r_data   <= i_req_data;
      r_active <= w_new_active;
      r_issued <= '0;
      r_done   <= '0;
    end else if (w_busy) begin
      r_issued <= r_issued | w_memreq_fire;
      r_done   <= r_done | w_capture;
    end
  end

  // Result gather. Store responses only mark a lane done, so the result data
  // for a store stays 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_resp_data <= '0;
    end else if (w_req_fire) begin
      r_resp_data <= '0;
    end else begin
      for (int i = 0; i < NLANES; i++) begin
        if (w_capture[i] && !r_rw) begin
          r_resp_data[i*DW +: DW] <= i_memresp_data[i*DW +: DW];
        end
      end
    end
  end

  // The lane address wraps modulo 2^AW. This lets a negative stride come out
  // as descending addresses.
  for (genvar g = 0; g < NLANES; g++) begin : g_lane_addr
    assign o_memreq_addr[g*AW +: AW] = r_addr + (r_stride * AW'(g));
  end

  assign o_req_rdy     = (r_state == ST_IDLE);
  assign o_resp_val    = (r_state == ST_RESP);
  assign o_resp_data   = r_resp_data;
  assign o_memreq_val  = w_memreq_val;
  assign o_memreq_rw   = r_rw;
  assign o_memreq_len  = r_len;
  assign o_memreq_data = r_data;

endmodule

// File: tb/tb_riscv_vec_mem_lane_unit.sv
// ---------------------------------------------------------------------------
// tb_riscv_vec_mem_lane_unit
//
// Directed bench for riscv_vec_mem_lane_unit in its default configuration.
// A one-cycle-latency memory model answers every issued lane. Load data is
// a fixed function of the lane address. Expected gathered results go into a
// scoreboard queue when a request is driven, and they are popped when the
// unit raises o_resp_val.
// ---------------------------------------------------------------------------
module tb_riscv_vec_mem_lane_unit;

  localparam int NL  = 8;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int VLW = 5;

  logic              clk;
  logic              rstN;
  logic              reqVal;
  logic              reqRdy;
  logic              reqRw;
  logic [1:0]        reqLen;
  logic [AW-1:0]     reqAddr;
  logic [AW-1:0]     reqStride;
  logic [VLW-1:0]    reqVl;
  logic [NL*DW-1:0]  reqData;
  logic              respVal;
  logic              respRdy;
  logic [NL*DW-1:0]  respData;
  logic [NL-1:0]     memreqVal;
  logic [NL-1:0]     memreqRdy;
  logic              memreqRw;
  logic [1:0]        memreqLen;
  logic [NL*AW-1:0]  memreqAddr;
  logic [NL*DW-1:0]  memreqData;
  logic [NL-1:0]     memrespVal;
  logic [NL*DW-1:0]  memrespData;

  int total = 0;
  int bad   = 0;

  logic [NL*DW-1:0] sb[$];
  logic [NL*AW-1:0] expAddr;

  // memory model state
  bit            memEn;
  logic [NL-1:0] pend;
  logic [NL-1:0] forceMask;
  logic [AW-1:0] pendAddr [NL];

  riscv_vec_mem_lane_unit #(.NLANES(NL), .AW(AW), .DW(DW), .VLW(VLW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_req_val      (reqVal),
    .o_req_rdy      (reqRdy),
    .i_req_rw       (reqRw),
    .i_req_len      (reqLen),
    .i_req_addr     (reqAddr),
    .i_req_stride   (reqStride),
    .i_req_vl       (reqVl),
    .i_req_data     (reqData),
    .o_resp_val     (respVal),
    .i_resp_rdy     (respRdy),
    .o_resp_data    (respData),
    .o_memreq_val   (memreqVal),
    .i_memreq_rdy   (memreqRdy),
    .o_memreq_rw    (memreqRw),
    .o_memreq_len   (memreqLen),
    .o_memreq_addr  (memreqAddr),
    .o_memreq_data  (memreqData),
    .i_memresp_val  (memrespVal),
    .i_memresp_data (memrespData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memFn(input logic [AW-1:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Record the lanes that fire at the rising edge. Their responses are
  // presented for the whole of the next cycle.
  always @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      pend[i] = memEn && memreqVal[i] && memreqRdy[i];
      if (pend[i]) pendAddr[i] = memreqAddr[i*AW +: AW];
    end
  end

  always @(negedge clk) begin
    memrespVal = pend | forceMask;
    for (int i = 0; i < NL; i++) begin
      if (forceMask[i])  memrespData[i*DW +: DW] = 32'hDEAD_BEEF;
      else if (pend[i])  memrespData[i*DW +: DW] = memFn(pendAddr[i]);
      else               memrespData[i*DW +: DW] = '0;
    end
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs,
                             input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request for one accepted cycle, and push its expected result.
  // The task returns in the middle of the cycle after the request fired.
  task automatic applyStimulus(input bit rw, input logic [AW-1:0] addr,
                               input logic [AW-1:0] stride,
                               input logic [VLW-1:0] vl,
                               input logic [NL*DW-1:0] data);
    logic [NL*DW-1:0] exp;
    logic [AW-1:0]    a;
    exp = '0;
    for (int i = 0; i < NL; i++) begin
      a = addr + stride * AW'(i);
      expAddr[i*AW +: AW] = a;
      if (!rw && i < int'(vl)) exp[i*DW +: DW] = memFn(a);
    end
    sb.push_back(exp);
    @(negedge clk);
    reqVal    = 1'b1;
    reqRw     = rw;
    reqLen    = 2'b10;
    reqAddr   = addr;
    reqStride = stride;
    reqVl     = vl;
    reqData   = data;
    @(negedge clk);
    reqVal    = 1'b0;
  endtask

  // Bounded wait for the gathered result, then check it and complete the
  // handshake.
  task automatic waitResp(input string tag, input int budget);
    int n;
    logic [NL*DW-1:0] exp;
    n = 0;
    while (!respVal && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_respval"}, 256'(respVal), 256'(1));
    checkOutput({tag, "_reqrdy_in_resp"}, 256'(reqRdy), 256'(0));
    exp = (sb.size() > 0) ? sb.pop_front() : '1;
    checkOutput({tag, "_respdata"}, 256'(respData), 256'(exp));
    respRdy = 1'b1;
    @(negedge clk);
    respRdy = 1'b0;
    checkOutput({tag, "_idle_after"}, 256'({reqRdy, respVal}), 256'(2'b10));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit seenResp;
    logic [NL*DW-1:0] stData;
    rstN = 1'b0; reqVal = 1'b0; reqRw = 1'b0; reqLen = '0; reqAddr = '0;
    reqStride = '0; reqVl = '0; reqData = '0; respRdy = 1'b0;
    memreqRdy = '1; memEn = 1'b1; forceMask = '0; pend = '0;
    memrespVal = '0; memrespData = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", 256'({reqRdy, respVal, memreqVal}), 256'({1'b1, 1'b0, 8'h00}));
    checkOutput("reset_respdata", 256'(respData), 256'(0));
    rstN = 1'b1;
    @(negedge clk);

    // Full-length load with fixed latency checks
    applyStimulus(1'b0, 32'h100, 32'd4, 5'd8, '0);
    checkOutput("ld8_memreqval_c1", 256'(memreqVal), 256'(8'hFF));
    checkOutput("ld8_addr", 256'(memreqAddr), 256'(expAddr));
    checkOutput("ld8_lane7_addr", 256'(memreqAddr[7*AW +: AW]), 256'(32'h11C));
    checkOutput("ld8_rw_len", 256'({memreqRw, memreqLen}), 256'(3'b010));
    @(negedge clk);
    checkOutput("ld8_respval_c2", 256'(respVal), 256'(0));
    @(negedge clk);
    checkOutput("ld8_respval_c3", 256'(respVal), 256'(1));
    waitResp("ld8", 1);

    // Short vector: only lanes 0..2 issue
    applyStimulus(1'b0, 32'h2000, 32'd8, 5'd3, '0);
    checkOutput("ld3_memreqval", 256'(memreqVal), 256'(8'h07));
    waitResp("ld3", 10);

    // Store with lane 5 stalled; other lanes must not wait for it
    for (int i = 0; i < NL; i++) stData[i*DW +: DW] = 32'h5100_0000 + i;
    memreqRdy = 8'hDF;
    applyStimulus(1'b1, 32'h400, 32'd4, 5'd8, stData);
    checkOutput("st_memreqval_c1", 256'(memreqVal), 256'(8'hFF));
    checkOutput("st_memreqdata", 256'(memreqData), 256'(stData));
    checkOutput("st_rw", 256'(memreqRw), 256'(1));
    @(negedge clk);
    checkOutput("st_only_lane5_left", 256'(memreqVal), 256'(8'h20));
    seenResp = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (respVal) seenResp = 1'b1;
    end
    checkOutput("st_no_resp_while_stalled", 256'(seenResp), 256'(0));
    memreqRdy = 8'hFF;
    @(negedge clk);
    checkOutput("st_lane5_issued", 256'(memreqVal), 256'(8'h00));
    checkOutput("st_respval_wait_resp", 256'(respVal), 256'(0));
    waitResp("st", 10);

    // vl = 0 goes straight to the result
    applyStimulus(1'b0, 32'h500, 32'd4, 5'd0, '0);
    checkOutput("vl0_respval_c1", 256'({respVal, memreqVal}), 256'({1'b1, 8'h00}));
    waitResp("vl0", 1);

    // vl = 20 clamps to NLANES
    applyStimulus(1'b0, 32'h600, 32'd4, 5'd20, '0);
    checkOutput("vl20_memreqval", 256'(memreqVal), 256'(8'hFF));
    waitResp("vl20", 10);

    // Address wrap-around
    applyStimulus(1'b0, 32'hFFFF_FFF8, 32'd4, 5'd8, '0);
    checkOutput("wrap_lane2_addr", 256'(memreqAddr[2*AW +: AW]), 256'(32'h0));
    checkOutput("wrap_addr", 256'(memreqAddr), 256'(expAddr));
    waitResp("wrap", 10);

    // Negative stride gives descending addresses
    applyStimulus(1'b0, 32'h1000, 32'hFFFF_FFFC, 5'd8, '0);
    checkOutput("neg_lane1_addr", 256'(memreqAddr[1*AW +: AW]), 256'(32'hFFC));
    checkOutput("neg_addr", 256'(memreqAddr), 256'(expAddr));
    waitResp("neg", 10);

    // Stride 0: all lanes target the same address
    applyStimulus(1'b0, 32'h700, 32'd0, 5'd8, '0);
    checkOutput("str0_lane7_addr", 256'(memreqAddr[7*AW +: AW]), 256'(32'h700));
    waitResp("str0", 10);

    // Reset while 4 lanes are outstanding; late responses must be ignored
    memEn = 1'b0;
    applyStimulus(1'b0, 32'h200, 32'd8, 5'd4, '0);
    checkOutput("rst_memreqval", 256'(memreqVal), 256'(8'h0F));
    @(negedge clk);
    checkOutput("rst_outstanding", 256'({respVal, memreqVal}), 256'({1'b0, 8'h00}));
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    sb.delete();
    @(posedge clk);
    forceMask = 8'h0F;
    @(posedge clk);
    forceMask = 8'h00;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_late_ignored", 256'({reqRdy, respVal, memreqVal}), 256'({1'b1, 1'b0, 8'h00}));
    checkOutput("rst_respdata_zero", 256'(respData), 256'(0));
    memEn = 1'b1;
    applyStimulus(1'b0, 32'h300, 32'h10, 5'd8, '0);
    waitResp("post_rst", 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
